// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, Rcon table and GF(2^8) helpers (modulus 0x11B)
// used by the cipher/inverse-cipher blocks of the AES datapath.
package aes_pkg;

   typedef enum logic [2:0] {IDLE, EXPAND, INIT_ARK, ROUND, DONE} state_t;

   typedef logic [31:0] word_t;

   // Rcon[rnd] for key-schedule round rnd = 1..10
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse; it maps 0 to 0, which the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (i != 0) r = gmul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round -- InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless 'last' is set.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [127:0] ark;
   logic [127:0] mix;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         // byte gi is row gi%4, column gi/4; its source is column (col - row) mod 4
         localparam int ROW = gi % 4;
         localparam int SRC = 4 * (((gi / 4) - ROW + 4) % 4) + ROW;
         assign ark[127 - 8*gi -: 8] = inv_sbox(state_in[127 - 8*SRC -: 8])
                                       ^ round_key[127 - 8*gi -: 8];
      end

      for (gi = 0; gi < 4; gi++) begin : g_col
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark[127 - 32*gi -: 8];
         assign a1 = ark[119 - 32*gi -: 8];
         assign a2 = ark[111 - 32*gi -: 8];
         assign a3 = ark[103 - 32*gi -: 8];
         assign mix[127 - 32*gi -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
   endgenerate

   assign state_out = last ? ark : mix;

endmodule

// File: rtl/decryption_block.sv
// decryption_block: iterative AES-128 inverse cipher, one round per clock; expands the key
// forward to rk10 and then walks the schedule backwards. Option: DECRYPT_KEY_CACHE_EN.
module decryption_block
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         decryptEnable,
   input  logic [127:0] key,
   input  logic [127:0] inputData,
   output logic [127:0] outputData,
   output logic         busy,
   output logic         done
);

   function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [3:0] rnd);
      word_t w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon(rnd), 24'h0};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // rk_rnd -> rk_(rnd-1): undo the word chain first, then recover w0 from the old w3
   function automatic logic [127:0] key_bwd(input logic [127:0] rk, input logic [3:0] rnd);
      word_t w0, w1, w2, w3;
      w3 = rk[31:0] ^ rk[63:32];
      w2 = rk[63:32] ^ rk[95:64];
      w1 = rk[95:64] ^ rk[127:96];
      w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rcon(rnd), 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   state_t       state_reg, state_next;
   logic [3:0]   cnt_reg;
   logic [127:0] key_reg;
   logic [127:0] data_reg;
   logic [127:0] out_reg;
   logic [127:0] key_fwd_next;
   logic [127:0] key_bwd_next;
   logic [127:0] round_out;
   logic         cache_hit;
   logic [127:0] cache_rk10;

   assign key_fwd_next = key_fwd(key_reg, cnt_reg + 4'd1);
   assign key_bwd_next = key_bwd(key_reg, cnt_reg + 4'd1);

   aes_inv_round u_round (
      .state_in  (data_reg),
      .round_key (key_bwd_next),
      .last      (cnt_reg == 4'd0),
      .state_out (round_out)
   );

`ifdef DECRYPT_KEY_CACHE_EN
   logic [127:0] cache_key_reg;
   logic [127:0] cache_rk10_reg;
   logic         cache_valid_reg;

   assign cache_hit  = cache_valid_reg && (key == cache_key_reg);
   assign cache_rk10 = cache_rk10_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid_reg <= 1'b0;
         cache_key_reg   <= '0;
         cache_rk10_reg  <= '0;
      end else if (state_reg == IDLE && decryptEnable && !cache_hit) begin
         cache_valid_reg <= 1'b0;
         cache_key_reg   <= key;
      end else if (state_reg == EXPAND && cnt_reg == 4'd9) begin
         cache_valid_reg <= 1'b1;
         cache_rk10_reg  <= key_fwd_next;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_rk10 = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (decryptEnable) state_next = cache_hit ? INIT_ARK : EXPAND;
         EXPAND:   if (cnt_reg == 4'd9) state_next = INIT_ARK;
         INIT_ARK: state_next = ROUND;
         ROUND:    if (cnt_reg == 4'd0) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         EXPAND, INIT_ARK, ROUND: busy = 1'b1;
         DONE:                    done = 1'b1;
         default:                 ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         key_reg  <= '0;
         data_reg <= '0;
         out_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: if (decryptEnable) begin
               key_reg  <= cache_hit ? cache_rk10 : key;
               data_reg <= inputData;
               cnt_reg  <= '0;
            end
            EXPAND: begin
               key_reg <= key_fwd_next;
               cnt_reg <= cnt_reg + 4'd1;
            end
            INIT_ARK: begin
               data_reg <= data_reg ^ key_reg;
               cnt_reg  <= 4'd9;
            end
            ROUND: begin
               key_reg  <= key_bwd_next;
               data_reg <= round_out;
               if (cnt_reg == 4'd0) out_reg <= round_out;
               else                 cnt_reg <= cnt_reg - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign outputData = out_reg;

endmodule

// File: tb/tb_decryption_block.sv
// tb_decryption_block: directed known-answer bench for decryption_block; also covers the
// DECRYPT_KEY_CACHE_EN build when that macro is defined.
module tb_decryption_block;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         decryptEnable = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] inputData = '0;
   logic [127:0] outputData;
   logic         busy;
   logic         done;

   int checks = 0;
   int failures = 0;

   logic         mc_valid = 1'b0;
   logic [127:0] mc_key = '0;

`ifdef DECRYPT_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h5E74E7BA66B0C7CC1B7697B3F9F51527;
   localparam logic [127:0] C2 = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
   localparam logic [127:0] P2 = 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D;
   localparam logic [127:0] K3 = 128'h33DE20E331BA5A525AB7C2495A767B5A;
   localparam logic [127:0] C3 = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
   localparam logic [127:0] P3 = 128'hE6FEBF30133874EBCB49226CD36D0D4F;

   always #5 clk = ~clk;

   decryption_block dut (
      .clk           (clk),
      .rst           (rst),
      .decryptEnable (decryptEnable),
      .key           (key),
      .inputData     (inputData),
      .outputData    (outputData),
      .busy          (busy),
      .done          (done)
   );

   function automatic int exp_lat(input logic [127:0] k);
      return (CACHE_EN && mc_valid && k == mc_key) ? 11 : 21;
   endfunction

   task automatic note_done(input logic [127:0] k);
      mc_valid = 1'b1;
      mc_key   = k;
   endtask

   // Called at a negedge; waits one more so the DUT is back in IDLE, then drives the start.
   task automatic start_op(input logic [127:0] k, input logic [127:0] d);
      @(negedge clk);
      key           = k;
      inputData     = d;
      decryptEnable = 1'b1;
   endtask

   // Returns the index of the first clock edge after the start edge at which done is seen.
   task automatic wait_done(input bit hold, input int n0, output int cyc);
      cyc = -1;
      for (int n = n0; n < 80 && cyc < 0; n++) begin
         @(negedge clk);
         if (n == 0 && !hold) decryptEnable = 1'b0;
         if (done) cyc = n;
      end
      $display("op key=%h out=%h cycles=%0d", key, outputData, cyc);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      decryptEnable = 1'b1;
      key = K1;
      inputData = C1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (outputData !== 128'h0) begin failures++; $display("FAIL reset_out got=%h want=0", outputData); end
      rst = 1'b0;
      decryptEnable = 1'b0;
      mc_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_fips_c1;
      int cyc;
      int lat;
      lat = exp_lat(K1);
      start_op(K1, C1);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1_busy_start got=%b want=1", busy); end
      decryptEnable = 1'b0;
      wait_done(1'b1, 1, cyc);
      checks++; if (cyc !== lat) begin failures++; $display("FAIL c1_latency got=%0d want=%0d", cyc, lat); end
      checks++; if (outputData !== P1) begin failures++; $display("FAIL c1_pt got=%h want=%h", outputData, P1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c1_busy_done got=%b want=0", busy); end
      note_done(K1);
   endtask

   task automatic test_back_to_back;
      int cyc;
      int lat;
      lat = exp_lat(K2);
      start_op(K2, C2);
      wait_done(1'b1, 0, cyc);
      checks++; if (cyc !== lat) begin failures++; $display("FAIL b2b_lat_a got=%0d want=%0d", cyc, lat); end
      checks++; if (outputData !== P2) begin failures++; $display("FAIL b2b_pt_a got=%h want=%h", outputData, P2); end
      note_done(K2);
      // decryptEnable stays high: IDLE for one cycle, then the next start edge
      key = K3;
      inputData = C3;
      lat = exp_lat(K3);
      wait_done(1'b1, 0, cyc);
      checks++; if (cyc !== lat + 1) begin failures++; $display("FAIL b2b_gap got=%0d want=%0d", cyc, lat + 1); end
      checks++; if (outputData !== P3) begin failures++; $display("FAIL b2b_pt_b got=%h want=%h", outputData, P3); end
      note_done(K3);
      decryptEnable = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid_op;
      int cyc;
      int seen;
      start_op(K1, C1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (n == 0) decryptEnable = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done); end
      checks++; if (outputData !== 128'h0) begin failures++; $display("FAIL midrst_out got=%h want=0", outputData); end
      rst = 1'b0;
      mc_valid = 1'b0;
      seen = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (busy || done) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_partial got=%0d want=0", seen); end
      start_op(K1, C1);
      wait_done(1'b0, 0, cyc);
      checks++; if (cyc !== 21) begin failures++; $display("FAIL midrst_restart_lat got=%0d want=21", cyc); end
      checks++; if (outputData !== P1) begin failures++; $display("FAIL midrst_restart_pt got=%h want=%h", outputData, P1); end
      note_done(K1);
   endtask

   task automatic test_ignore_changes;
      int cyc;
      int lat;
      int extra;
      lat = exp_lat(K2);
      start_op(K2, C2);
      cyc = -1;
      for (int n = 0; n < 80 && cyc < 0; n++) begin
         @(negedge clk);
         case (n)
            0: decryptEnable = 1'b0;
            5: begin key = K1; inputData = C1; decryptEnable = 1'b1; end
            6: decryptEnable = 1'b0;
            7: decryptEnable = 1'b1;
            8: decryptEnable = 1'b0;
            default: ;
         endcase
         if (done) cyc = n;
      end
      $display("op key=%h out=%h cycles=%0d", K2, outputData, cyc);
      checks++; if (cyc !== lat) begin failures++; $display("FAIL ign_lat got=%0d want=%0d", cyc, lat); end
      checks++; if (outputData !== P2) begin failures++; $display("FAIL ign_pt got=%h want=%h", outputData, P2); end
      note_done(K2);
      extra = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL ign_no_restart got=%0d want=0", extra); end
   endtask

`ifdef DECRYPT_KEY_CACHE_EN
   task automatic test_cache;
      int cyc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mc_valid = 1'b0;
      start_op(K1, C1);
      wait_done(1'b0, 0, cyc);
      checks++; if (cyc !== 21) begin failures++; $display("FAIL cache_first_lat got=%0d want=21", cyc); end
      checks++; if (outputData !== P1) begin failures++; $display("FAIL cache_first_pt got=%h want=%h", outputData, P1); end
      start_op(K1, C1);
      wait_done(1'b0, 0, cyc);
      checks++; if (cyc !== 11) begin failures++; $display("FAIL cache_hit_lat got=%0d want=11", cyc); end
      checks++; if (outputData !== P1) begin failures++; $display("FAIL cache_hit_pt got=%h want=%h", outputData, P1); end
      start_op(K2, C2);
      wait_done(1'b0, 0, cyc);
      checks++; if (cyc !== 21) begin failures++; $display("FAIL cache_miss_lat got=%0d want=21", cyc); end
      checks++; if (outputData !== P2) begin failures++; $display("FAIL cache_miss_pt got=%h want=%h", outputData, P2); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_fips_c1();
      test_back_to_back();
      test_reset_mid_op();
      test_ignore_changes();
`ifdef DECRYPT_KEY_CACHE_EN
      test_cache();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
